int_writeback_buffer: RTL and testbench

INT_WRITEBACK_BUFFER -- requirements
Module: int_writeback_buffer

---
 rtl/int_writeback_buffer_pkg.sv | 17 +
 rtl/int_writeback_buffer.sv | 61 ++++++
 tb/tb_int_writeback_buffer.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/int_writeback_buffer_pkg.sv
// int_writeback_buffer_pkg: shared vector/result types and default buffer depth for the writeback path
package int_writeback_buffer_pkg;
  localparam int VEC_WIDTH = 16;
  localparam int DWIDTH = 8;
  localparam int REG_BITS = 5;
  localparam int RSV_BITS = 4;
  localparam int WB_DEPTH = 4;
  typedef logic [VEC_WIDTH-1:0][DWIDTH-1:0] Vector_t;
  typedef logic [VEC_WIDTH-1:0] Mask_t;
  typedef logic [RSV_BITS-1:0] RsvID_t;
  typedef struct packed {
    Vector_t vec;
    Mask_t mask;
    logic [REG_BITS-1:0] dst_reg;
    RsvID_t rid;
  } WbEntry_t;
endpackage

// File: rtl/int_writeback_buffer.sv
// int_writeback_buffer: FIFO of integer exec results feeding the register-file write port
module int_writeback_buffer
  import int_writeback_buffer_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  Vector_t                  in_vec,
  input  Mask_t                    in_mask,
  input  logic [REG_BITS-1:0]      in_dst_reg,
  input  RsvID_t                   in_rid,
  output logic                     stall,
  output logic                     wb_valid,
  input  logic                     wb_ready,
  output Vector_t                  wb_vec,
  output Mask_t                    wb_mask,
  output logic [REG_BITS-1:0]      wb_dst_reg,
  output logic                     done_valid,
  output RsvID_t                   done_rid,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic [CNT_W-1:0]         stall_cycles
);
  localparam int PW = $clog2(DEPTH);
  WbEntry_t mem [DEPTH];
  WbEntry_t head;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0] count;
  logic push, pop, nonempty;
  assign head = mem[rd_ptr];
  assign nonempty = count != '0;
  assign stall = count == (PW+1)'(DEPTH);
  assign push = in_valid && !stall;
  // masked-off results carry no register write, so they retire without the handshake
  assign wb_valid = nonempty && |head.mask;
  assign pop = nonempty && (!(|head.mask) || wb_ready);
  assign done_valid = pop;
  assign done_rid = head.rid;
  assign wb_vec = head.vec;
  assign wb_mask = head.mask;
  assign wb_dst_reg = head.dst_reg;
  assign occupancy = count;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      stall_cycles <= '0;
    end else begin
      wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
      stall_cycles <= (stall && !(&stall_cycles)) ? stall_cycles + 1'b1 : stall_cycles;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{vec: in_vec, mask: in_mask, dst_reg: in_dst_reg, rid: in_rid};
  end
endmodule

// File: tb/tb_int_writeback_buffer.sv
// tb_int_writeback_buffer: directed stimulus with a queue scoreboard of accepted results
module tb_int_writeback_buffer;
  import int_writeback_buffer_pkg::*;
  localparam int DEPTH = 4;
  localparam int CNT_W = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  Vector_t in_vec = '0;
  Mask_t in_mask = '0;
  logic [REG_BITS-1:0] in_dst_reg = '0;
  RsvID_t in_rid = '0;
  logic stall, wb_valid, done_valid;
  logic wb_ready = 1'b0;
  Vector_t wb_vec;
  Mask_t wb_mask;
  logic [REG_BITS-1:0] wb_dst_reg;
  RsvID_t done_rid;
  logic [$clog2(DEPTH):0] occupancy;
  logic [CNT_W-1:0] stall_cycles;
  int checks = 0;
  int fails = 0;
  WbEntry_t exp_q [$];

  int_writeback_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_vec(in_vec), .in_mask(in_mask),
    .in_dst_reg(in_dst_reg), .in_rid(in_rid), .stall(stall), .wb_valid(wb_valid),
    .wb_ready(wb_ready), .wb_vec(wb_vec), .wb_mask(wb_mask), .wb_dst_reg(wb_dst_reg),
    .done_valid(done_valid), .done_rid(done_rid), .occupancy(occupancy),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // reference model: sampled mid-cycle while inputs and outputs are settled
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      chk("rst_occ", 128'(occupancy), 128'(0));
      chk("rst_wb_valid", 128'(wb_valid), 128'(0));
      chk("rst_done", 128'(done_valid), 128'(0));
      chk("rst_stall", 128'(stall), 128'(0));
    end else begin
      automatic bit full = exp_q.size() == DEPTH;
      automatic bit accept = in_valid && !full;
      automatic bit have = exp_q.size() != 0;
      automatic bit m_wb = have && (exp_q[0].mask != '0);
      automatic bit m_pop = have && (exp_q[0].mask == '0 || wb_ready);
      chk("occupancy", 128'(occupancy), 128'(exp_q.size()));
      chk("stall", 128'(stall), 128'(full));
      chk("wb_valid", 128'(wb_valid), 128'(m_wb));
      chk("done_valid", 128'(done_valid), 128'(m_pop));
      if (m_wb) begin
        chk("wb_vec", 128'(wb_vec), 128'(exp_q[0].vec));
        chk("wb_mask", 128'(wb_mask), 128'(exp_q[0].mask));
        chk("wb_dst", 128'(wb_dst_reg), 128'(exp_q[0].dst_reg));
      end
      if (m_pop) begin
        chk("done_rid", 128'(done_rid), 128'(exp_q[0].rid));
        void'(exp_q.pop_front());
      end
      if (accept) exp_q.push_back('{vec: in_vec, mask: in_mask, dst_reg: in_dst_reg, rid: in_rid});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input int rid, input Mask_t m);
    in_valid = v;
    in_rid = RsvID_t'(rid);
    in_dst_reg = REG_BITS'(rid);
    in_mask = m;
    in_vec = {VEC_WIDTH{8'(rid) + 8'h10}};
  endtask

  task automatic push1(input int rid, input Mask_t m);
    drive(1'b1, rid, m);
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    step();
    step();
    chk("reset_stall_cycles", 128'(stall_cycles), 128'(0));
    rst = 1'b0;
    step();
    // single result with full mask, immediate write-back
    wb_ready = 1'b1;
    drive(1'b1, 2, 16'hFFFF);
    in_dst_reg = 5'd3;
    in_vec = {VEC_WIDTH{8'h11}};
    step();
    in_valid = 1'b0;
    chk("t1_wb_valid", 128'(wb_valid), 128'(1));
    chk("t1_dst", 128'(wb_dst_reg), 128'(3));
    chk("t1_vec", 128'(wb_vec), 128'({VEC_WIDTH{8'h11}}));
    chk("t1_done", 128'(done_valid), 128'(1));
    chk("t1_rid", 128'(done_rid), 128'(2));
    step();
    // masked-off result retires without a write
    wb_ready = 1'b0;
    push1(5, 16'h0000);
    chk("t2_wb_valid", 128'(wb_valid), 128'(0));
    chk("t2_done", 128'(done_valid), 128'(1));
    chk("t2_rid", 128'(done_rid), 128'(5));
    step();
    // fill to full with writes blocked
    for (int i = 1; i <= 4; i++) push1(i, 16'h00F0 << i);
    chk("t3_stall", 128'(stall), 128'(1));
    drive(1'b1, 9, 16'hFFFF);
    step();
    step();
    chk("t3_occ_held", 128'(occupancy), 128'(4));
    chk("t3_payload_stable", 128'(wb_dst_reg), 128'(1));
    in_valid = 1'b0;
    wb_ready = 1'b1;
    chk("t3_first_pop_rid", 128'(done_rid), 128'(1));
    step();
    chk("t3_stall_drop", 128'(stall), 128'(0));
    repeat (4) step();
    chk("t3_empty", 128'(occupancy), 128'(0));
    // full, pop and offered push in one cycle
    wb_ready = 1'b0;
    for (int i = 1; i <= 4; i++) push1(i + 10, 16'hFFFF);
    wb_ready = 1'b1;
    drive(1'b1, 7, 16'hFFFF);
    step();
    in_valid = 1'b0;
    wb_ready = 1'b0;
    chk("t4_occ", 128'(occupancy), 128'(3));
    chk("t4_stall", 128'(stall), 128'(0));
    step();
    // stall-cycle counter counts then saturates
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 1; i <= 4; i++) push1(i, 16'h0F0F);
    chk("t5_cnt0", 128'(stall_cycles), 128'(0));
    repeat (10) step();
    chk("t5_cnt10", 128'(stall_cycles), 128'(10));
    repeat ((1 << CNT_W) - 5) step();
    chk("t5_sat", 128'(stall_cycles), 128'(16'hFFFF));
    // asynchronous reset with entries buffered
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 1; i <= 3; i++) push1(i, 16'hFFFF);
    chk("t6_occ_pre", 128'(occupancy), 128'(3));
    #2;
    wb_ready = 1'b1;
    rst = 1'b1;
    #1;
    chk("t6_occ", 128'(occupancy), 128'(0));
    chk("t6_wb_valid", 128'(wb_valid), 128'(0));
    chk("t6_done", 128'(done_valid), 128'(0));
    chk("t6_cnt", 128'(stall_cycles), 128'(0));
    step();
    rst = 1'b0;
    step();
    chk("t6_still_empty", 128'(occupancy), 128'(0));
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
